rs_issue_select: RTL and testbench

//  Issue arbiter directly downstream of the RS group. Each cycle it picks up to N_WAY

---
 rtl/rs_issue_if.sv | 28 ++
 rtl/rs_issue_select.sv | 119 +++++++++++
 tb/tb_rs_issue_select.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_issue_if.sv
// Issue-select bus between the RS group and the issue arbiter.
// The RS group (master) presents per-class wake-up vectors and memory
// readiness; the arbiter (slave) returns per-lane one-hot grants.
interface rs_issue_if #(
  parameter int RS_SIZE = 16,
  parameter int N_WAY   = 3
);
  logic                       flush;
  logic [RS_SIZE-1:0]         wake_up_alu;
  logic [RS_SIZE-1:0]         wake_up_mul;
  logic [RS_SIZE-1:0]         wake_up_mem;
  logic [RS_SIZE-1:0]         wake_up_bcond;
  logic                       mem_ready;
  logic [RS_SIZE*N_WAY-1:0]   issue_select;
  logic [RS_SIZE-1:0]         rs1_use_en;
  logic                       mul_busy;
  logic [1:0]                 issue_count;

  modport master (
    output flush, wake_up_alu, wake_up_mul, wake_up_mem, wake_up_bcond, mem_ready,
    input  issue_select, rs1_use_en, mul_busy, issue_count
  );

  modport slave (
    input  flush, wake_up_alu, wake_up_mul, wake_up_mem, wake_up_bcond, mem_ready,
    output issue_select, rs1_use_en, mul_busy, issue_count
  );
endinterface

// File: rtl/rs_issue_select.sv
// Three-lane issue arbiter sitting directly after the RS group.
// Grants are combinational (same cycle). Lane0 takes BCOND or ALU, lane1
// takes MUL or ALU, lane2 takes MEM or ALU. Entries are searched round-robin
// from ptr, and the non-pipelined multiplier blocks further MUL issue for
// MUL_LAT cycles.
module rs_issue_select #(
  parameter int RS_SIZE = 16,
  parameter int N_WAY   = 3,
  parameter int MUL_LAT = 4
) (
  input logic      clk,
  input logic      rst,
  rs_issue_if.slave bus
);

  localparam int PTR_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;

  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] mul_cnt;

  logic [RS_SIZE-1:0] bcond_el;
  logic [RS_SIZE-1:0] mul_el;
  logic [RS_SIZE-1:0] mem_el;
  logic [RS_SIZE-1:0] alu_el;

  logic [RS_SIZE-1:0] g0_bcond, g0_alu, g0;
  logic [RS_SIZE-1:0] g1_mul, g1_alu, g1;
  logic [RS_SIZE-1:0] g2_mem, g2_alu, g2;

  logic [N_WAY-1:0][RS_SIZE-1:0] grant;
  logic [N_WAY-1:0]              lane_vld;
  logic                          blocked;
  logic                          mul_grant;
  logic [1:0]                    issue_count;

  // First set bit of vec searching start, start+1, ..., wrapping at RS_SIZE.
  function automatic logic [RS_SIZE-1:0] rr_pick(input logic [RS_SIZE-1:0] vec,
                                                 input logic [PTR_W-1:0]   start);
    logic [RS_SIZE-1:0] g;
    logic               found;
    logic [PTR_W-1:0]   idx;
    int                 j;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      j = int'(start) + i;
      if (j >= RS_SIZE) j = j - RS_SIZE;
      idx = PTR_W'(j);
      if (!found && vec[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // Each entry competes only in its highest class: BCOND > MUL > MEM > ALU.
  always_comb begin
    bcond_el = bus.wake_up_bcond;
    mul_el   = bus.wake_up_mul & ~bus.wake_up_bcond;
    mem_el   = bus.wake_up_mem & ~bus.wake_up_mul & ~bus.wake_up_bcond;
    alu_el   = bus.wake_up_alu & ~bus.wake_up_mem & ~bus.wake_up_mul & ~bus.wake_up_bcond;
  end

  // Lane picks; ALU fallback excludes entries already taken by lower lanes.
  always_comb begin
    blocked  = rst | bus.flush;

    g0_bcond = rr_pick(bcond_el, ptr);
    g0_alu   = rr_pick(alu_el, ptr);
    g0       = (|g0_bcond) ? g0_bcond : g0_alu;

    g1_mul   = (mul_cnt == '0) ? rr_pick(mul_el, ptr) : '0;
    g1_alu   = rr_pick(alu_el & ~g0, ptr);
    g1       = (|g1_mul) ? g1_mul : g1_alu;

    g2_mem   = bus.mem_ready ? rr_pick(mem_el, ptr) : '0;
    g2_alu   = rr_pick(alu_el & ~g0 & ~g1, ptr);
    g2       = (|g2_mem) ? g2_mem : g2_alu;

    grant    = '0;
    if (!blocked) begin
      grant[0] = g0;
      grant[1] = g1;
      grant[2] = g2;
    end

    for (int k = 0; k < N_WAY; k++) lane_vld[k] = |grant[k];

    mul_grant   = !blocked && (|g1_mul);
    issue_count = {1'b0, lane_vld[0]} + {1'b0, lane_vld[1]} + {1'b0, lane_vld[2]};
  end

  // Drive the bus; rs1_use_en frees every entry granted on any lane.
  always_comb begin
    bus.issue_select = grant;
    bus.rs1_use_en   = grant[0] | grant[1] | grant[2];
    bus.issue_count  = issue_count;
    bus.mul_busy     = (mul_cnt != '0);
  end

  // Round-robin pointer advances on any issue; multiplier countdown keeps
  // running through flush since an in-flight multiply is not cancelled.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      mul_cnt <= '0;
    end else begin
      if (issue_count != 2'd0) begin
        if (ptr == PTR_W'(RS_SIZE - 1)) ptr <= '0;
        else                            ptr <= ptr + PTR_W'(1);
      end
      if (mul_grant)            mul_cnt <= CNT_W'(MUL_LAT - 1);
      else if (mul_cnt != '0)   mul_cnt <= mul_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rs_issue_select.sv
// Directed bench for rs_issue_select (RS_SIZE=16, N_WAY=3, MUL_LAT=4).
module tb_rs_issue_select;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rs_issue_if #(.RS_SIZE(16), .N_WAY(3)) bus ();

  rs_issue_select #(.RS_SIZE(16), .N_WAY(3), .MUL_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus.flush         = 1'b0;
    bus.wake_up_alu   = 16'h0000;
    bus.wake_up_mul   = 16'h0000;
    bus.wake_up_mem   = 16'h0000;
    bus.wake_up_bcond = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst               = 1'b1;
    bus.flush         = 1'b0;
    bus.mem_ready     = 1'b1;
    bus.wake_up_alu   = 16'hFFFF;
    bus.wake_up_mul   = 16'hFFFF;
    bus.wake_up_mem   = 16'hFFFF;
    bus.wake_up_bcond = 16'hFFFF;
    #1;
    total++;
    if (bus.issue_select !== 48'h0) begin
      bad++; $display("FAIL reset_sel got=%h need=%h", bus.issue_select, 48'h0);
    end
    total++;
    if (bus.rs1_use_en !== 16'h0) begin
      bad++; $display("FAIL reset_use got=%h need=%h", bus.rs1_use_en, 16'h0);
    end
    total++;
    if (bus.issue_count !== 2'd0) begin
      bad++; $display("FAIL reset_count got=%0d need=0", bus.issue_count);
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    total++;
    if (dut.ptr !== 4'd0) begin
      bad++; $display("FAIL reset_ptr got=%0d need=0", dut.ptr);
    end
    total++;
    if (bus.mul_busy !== 1'b0) begin
      bad++; $display("FAIL reset_mul_busy got=%b need=0", bus.mul_busy);
    end
    total++;
    if (bus.issue_select !== 48'h0 || bus.issue_count !== 2'd0) begin
      bad++; $display("FAIL idle_outputs got=%h/%0d need=0/0", bus.issue_select, bus.issue_count);
    end
    tick();
    total++;
    if (dut.ptr !== 4'd0) begin
      bad++; $display("FAIL idle_ptr_hold got=%0d need=0", dut.ptr);
    end
  endtask

  task automatic test_alu_fill();
    bus.wake_up_alu = 16'h0007;
    #1;
    total++;
    if (bus.issue_select !== {16'h0004, 16'h0002, 16'h0001}) begin
      bad++; $display("FAIL alu_fill_sel got=%h need=%h", bus.issue_select, {16'h0004, 16'h0002, 16'h0001});
    end
    total++;
    if (bus.rs1_use_en !== 16'h0007) begin
      bad++; $display("FAIL alu_fill_use got=%h need=0007", bus.rs1_use_en);
    end
    total++;
    if (bus.issue_count !== 2'd3) begin
      bad++; $display("FAIL alu_fill_count got=%0d need=3", bus.issue_count);
    end
    tick();
    clear_inputs();
    total++;
    if (dut.ptr !== 4'd1) begin
      bad++; $display("FAIL alu_fill_ptr got=%0d need=1", dut.ptr);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 14; i++) begin
      bus.wake_up_alu = 16'h0001;
      tick();
    end
    clear_inputs();
    #1;
    total++;
    if (dut.ptr !== 4'd15) begin
      bad++; $display("FAIL wrap_setup_ptr got=%0d need=15", dut.ptr);
    end
    bus.wake_up_alu = 16'h8001;
    #1;
    total++;
    if (bus.issue_select !== {16'h0000, 16'h0001, 16'h8000}) begin
      bad++; $display("FAIL wrap_sel got=%h need=%h", bus.issue_select, {16'h0000, 16'h0001, 16'h8000});
    end
    total++;
    if (bus.issue_count !== 2'd2) begin
      bad++; $display("FAIL wrap_count got=%0d need=2", bus.issue_count);
    end
    tick();
    clear_inputs();
    total++;
    if (dut.ptr !== 4'd0) begin
      bad++; $display("FAIL wrap_ptr got=%0d need=0", dut.ptr);
    end
  endtask

  task automatic test_mul_occupancy();
    bus.wake_up_mul = 16'h0030;
    #1;
    total++;
    if (bus.issue_select !== {16'h0000, 16'h0010, 16'h0000} || bus.issue_count !== 2'd1) begin
      bad++; $display("FAIL mul_first got=%h/%0d need=%h/1", bus.issue_select, bus.issue_count, {16'h0000, 16'h0010, 16'h0000});
    end
    tick();
    bus.wake_up_mul = 16'h0020;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (bus.issue_select !== 48'h0 || bus.mul_busy !== 1'b1) begin
        bad++; $display("FAIL mul_blocked_%0d got=%h/%b need=0/1", c, bus.issue_select, bus.mul_busy);
      end
      tick();
    end
    #1;
    total++;
    if (bus.issue_select !== {16'h0000, 16'h0020, 16'h0000} || bus.mul_busy !== 1'b0) begin
      bad++; $display("FAIL mul_second got=%h/%b need=%h/0", bus.issue_select, bus.mul_busy, {16'h0000, 16'h0020, 16'h0000});
    end
    tick();
    clear_inputs();
    total++;
    if (dut.mul_cnt !== 3'd3 || dut.ptr !== 4'd2) begin
      bad++; $display("FAIL mul_state got=%0d/%0d need=3/2", dut.mul_cnt, dut.ptr);
    end
  endtask

  task automatic test_mem_ready();
    bus.mem_ready   = 1'b0;
    bus.wake_up_mem = 16'h0100;
    bus.wake_up_alu = 16'h0001;
    #1;
    total++;
    if (bus.issue_select !== {16'h0000, 16'h0000, 16'h0001} || bus.issue_count !== 2'd1) begin
      bad++; $display("FAIL mem_not_ready got=%h/%0d need=%h/1", bus.issue_select, bus.issue_count, {16'h0000, 16'h0000, 16'h0001});
    end
    bus.mem_ready = 1'b1;
    #1;
    total++;
    if (bus.issue_select !== {16'h0100, 16'h0000, 16'h0001} || bus.issue_count !== 2'd2) begin
      bad++; $display("FAIL mem_ready got=%h/%0d need=%h/2", bus.issue_select, bus.issue_count, {16'h0100, 16'h0000, 16'h0001});
    end
    total++;
    if (bus.rs1_use_en !== 16'h0101) begin
      bad++; $display("FAIL mem_use got=%h need=0101", bus.rs1_use_en);
    end
    tick();
    clear_inputs();
    total++;
    if (dut.ptr !== 4'd3 || dut.mul_cnt !== 3'd2) begin
      bad++; $display("FAIL mem_state got=%0d/%0d need=3/2", dut.ptr, dut.mul_cnt);
    end
  endtask

  task automatic test_flush();
    bus.flush         = 1'b1;
    bus.wake_up_bcond = 16'h0002;
    #1;
    total++;
    if (bus.issue_select !== 48'h0 || bus.rs1_use_en !== 16'h0 || bus.issue_count !== 2'd0) begin
      bad++; $display("FAIL flush_grants got=%h/%h/%0d need=0/0/0", bus.issue_select, bus.rs1_use_en, bus.issue_count);
    end
    tick();
    total++;
    if (dut.ptr !== 4'd3 || dut.mul_cnt !== 3'd1) begin
      bad++; $display("FAIL flush_state got=%0d/%0d need=3/1", dut.ptr, dut.mul_cnt);
    end
    bus.flush = 1'b0;
    #1;
    total++;
    if (bus.issue_select !== {16'h0000, 16'h0000, 16'h0002}) begin
      bad++; $display("FAIL after_flush_bcond got=%h need=%h", bus.issue_select, {16'h0000, 16'h0000, 16'h0002});
    end
    tick();
    clear_inputs();
    total++;
    if (dut.ptr !== 4'd4 || bus.mul_busy !== 1'b0) begin
      bad++; $display("FAIL after_flush_state got=%0d/%b need=4/0", dut.ptr, bus.mul_busy);
    end
  endtask

  task automatic test_class_priority();
    bus.mem_ready     = 1'b1;
    bus.wake_up_bcond = 16'h0040;
    bus.wake_up_mul   = 16'h00C0;
    bus.wake_up_mem   = 16'h0180;
    bus.wake_up_alu   = 16'h0340;
    #1;
    total++;
    if (bus.issue_select !== {16'h0100, 16'h0080, 16'h0040} || bus.issue_count !== 2'd3) begin
      bad++; $display("FAIL prio_sel got=%h/%0d need=%h/3", bus.issue_select, bus.issue_count, {16'h0100, 16'h0080, 16'h0040});
    end
    bus.mem_ready = 1'b0;
    #1;
    total++;
    if (bus.issue_select !== {16'h0200, 16'h0080, 16'h0040}) begin
      bad++; $display("FAIL prio_alu_fallback got=%h need=%h", bus.issue_select, {16'h0200, 16'h0080, 16'h0040});
    end
    tick();
    clear_inputs();
    total++;
    if (dut.mul_cnt !== 3'd3 || dut.ptr !== 4'd5) begin
      bad++; $display("FAIL prio_state got=%0d/%0d need=3/5", dut.mul_cnt, dut.ptr);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.mem_ready = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_alu_fill();
    test_wrap();
    test_mul_occupancy();
    test_mem_ready();
    test_flush();
    test_class_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
